usb_tx_pkt: RTL and testbench



---
 rtl/usb_pkt_pkg.sv | 48 ++++
 rtl/usb_crc16.sv | 29 ++
 rtl/usb_tx_pkt.sv | 199 +++++++++++++++++++
 tb/tb_usb_tx_pkt.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// Shared USB transmit definitions: PID codes, packet classes, tx FSM states, CRC16 constants.
// The GAP state exists only when USB_TX_PKT_IPG_EN is defined.
package usb_pkt_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

`ifdef USB_TX_PKT_IPG_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_END, ST_GAP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_END
  } tx_state_t;
`endif

  typedef enum logic [1:0] {
    CLS_OTHER, CLS_HANDSHAKE, CLS_DATA
  } pkt_class_t;

  // Packet class is carried in the low two PID bits.
  function automatic pkt_class_t pid_class(input logic [1:0] pid_lo);
    case (pid_lo)
      2'b11:   return CLS_DATA;
      2'b10:   return CLS_HANDSHAKE;
      default: return CLS_OTHER;
    endcase
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// One-byte step of the USB CRC16 (poly 0x8005, reflected, LSB first).
module usb_crc16
  import usb_pkt_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {8'h00, data};
    for (int b = 0; b < 8; b++) begin
      acc = acc[0] ? ((acc >> 1) ^ POLY_REFL) : (acc >> 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/usb_tx_pkt.sv
// UTMI transmit packet assembler: PID byte, payload, then inverted CRC16 for data packets.
// Define USB_TX_PKT_IPG_EN to insert an IPG_CYCLES inter-packet gap after every packet.
module usb_tx_pkt
  import usb_pkt_pkg::*;
#(
  parameter int MAX_PKT = 1023
`ifdef USB_TX_PKT_IPG_EN
  ,
  parameter int IPG_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_i,
  input  logic [3:0] pid_i,
  input  logic       zlp_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [7:0] DataOut_o,
  output logic       TxValid_o,
  input  logic       TxReady_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_PKT);

`ifdef USB_TX_PKT_IPG_EN
  localparam int IPG_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  logic [IPG_W-1:0] ipg_cnt, ipg_n;
`endif

  tx_state_t   state, state_n;
  pkt_class_t  cls_q, cls_n;
  logic [7:0]  hold, hold_n;
  logic        tx_valid, tx_valid_n;
  logic [15:0] crc, crc_n, crc_step;
  logic [10:0] cnt, cnt_n;
  logic        last_q, last_n;
  logic        zlp_q, zlp_n;
  logic        err_q, err_n;
  logic        accept;
  logic        want_load;

  usb_crc16 u_crc (
    .crc_in  (crc),
    .data    (data_i),
    .crc_out (crc_step)
  );

  assign accept    = tx_valid & TxReady_i;
  assign DataOut_o = hold;
  assign TxValid_o = tx_valid;
  assign busy_o    = (state != ST_IDLE);
  assign err_o     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cls_q    <= CLS_OTHER;
      hold     <= 8'h00;
      tx_valid <= 1'b0;
      crc      <= CRC16_INIT;
      cnt      <= '0;
      last_q   <= 1'b0;
      zlp_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef USB_TX_PKT_IPG_EN
      ipg_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      cls_q    <= cls_n;
      hold     <= hold_n;
      tx_valid <= tx_valid_n;
      crc      <= crc_n;
      cnt      <= cnt_n;
      last_q   <= last_n;
      zlp_q    <= zlp_n;
      err_q    <= err_n;
`ifdef USB_TX_PKT_IPG_EN
      ipg_cnt  <= ipg_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cls_n        = cls_q;
    hold_n       = hold;
    tx_valid_n   = tx_valid;
    crc_n        = crc;
    cnt_n        = cnt;
    last_n       = last_q;
    zlp_n        = zlp_q;
    err_n        = 1'b0;
    want_load    = 1'b0;
    data_ready_o = 1'b0;
    done_o       = 1'b0;
`ifdef USB_TX_PKT_IPG_EN
    ipg_n        = ipg_cnt;
`endif

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (send_i) begin
          hold_n     = pid_byte(pid_i);
          cls_n      = pid_class(pid_i[1:0]);
          zlp_n      = zlp_i;
          last_n     = 1'b0;
          crc_n      = CRC16_INIT;
          tx_valid_n = 1'b1;
          state_n    = ST_PID;
        end
      end
      ST_PID: begin
        if (accept) begin
          if (cls_q != CLS_DATA) begin
            tx_valid_n = 1'b0;
            state_n    = ST_END;
          end else if (zlp_q) begin
            hold_n  = ~crc[7:0];
            state_n = ST_CRC_LO;
          end else begin
            want_load = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (last_q) begin
            hold_n  = ~crc[7:0];
            state_n = ST_CRC_LO;
          end else begin
            want_load = 1'b1;
          end
        end
      end
      ST_CRC_LO: begin
        if (accept) begin
          hold_n  = ~crc[15:8];
          state_n = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (accept) begin
          tx_valid_n = 1'b0;
          state_n    = ST_END;
        end
      end
      ST_END: begin
        done_o = 1'b1;
        crc_n  = CRC16_INIT;
`ifdef USB_TX_PKT_IPG_EN
        ipg_n   = IPG_W'(IPG_CYCLES - 1);
        state_n = ST_GAP;
`else
        state_n = ST_IDLE;
`endif
      end
`ifdef USB_TX_PKT_IPG_EN
      ST_GAP: begin
        if (ipg_cnt == '0) state_n = ST_IDLE;
        else               ipg_n   = ipg_cnt - 1'b1;
      end
`endif
      default: begin
        tx_valid_n = 1'b0;
        state_n    = ST_IDLE;
      end
    endcase

    // A payload load either consumes the byte or aborts on underrun / overrun.
    if (want_load) begin
      if (data_valid_i && (cnt < MAX_CNT)) begin
        data_ready_o = 1'b1;
        hold_n       = data_i;
        crc_n        = crc_step;
        last_n       = data_last_i;
        cnt_n        = cnt + 11'd1;
        state_n      = ST_DATA;
      end else begin
        err_n      = 1'b1;
        tx_valid_n = 1'b0;
        crc_n      = CRC16_INIT;
        state_n    = ST_IDLE;
      end
    end
  end

  if (MAX_PKT < 1 || MAX_PKT > 2047) begin : g_bad_max_pkt
    $error("MAX_PKT must fit the 11-bit payload counter");
  end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Self-checking bench for usb_tx_pkt: directed scenarios plus randomized packets
// checked against a queue-based packet/CRC reference model.
module tb_usb_tx_pkt;
  import usb_pkt_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send_i = 1'b0;
  logic [3:0] pid_i = 4'h0;
  logic       zlp_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       data_valid_i = 1'b0;
  logic       data_last_i = 1'b0;
  logic       data_ready_o;
  logic [7:0] DataOut_o;
  logic       TxValid_o;
  logic       TxReady_i = 1'b0;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_cmp = 0;
  int n_bad = 0;

  byte_q_t pay;
  byte_q_t obs;
  byte_q_t exp_q;
  bit      got_done, got_err, timed_out;
  int      dr_cnt, stab_bad, lat, wait_cyc;
  logic    valid_at_end, busy_at_end;

  logic [3:0] pids [12] = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0, PID_DATA1,
                            PID_DATA2, PID_MDATA, PID_ACK, PID_NAK, PID_STALL, PID_NYET};

  usb_tx_pkt dut (
    .clk          (clk),
    .rst          (rst),
    .send_i       (send_i),
    .pid_i        (pid_i),
    .zlp_i        (zlp_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_last_i  (data_last_i),
    .data_ready_o (data_ready_o),
    .DataOut_o    (DataOut_o),
    .TxValid_o    (TxValid_o),
    .TxReady_i    (TxReady_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Reference: PID byte, payload, then complement of the LSB-first CRC16 (reflected poly A001).
  function automatic byte_q_t model_pkt(input logic [3:0] pid, input bit zlp, input byte_q_t p);
    byte_q_t q;
    logic [15:0] r;
    logic fb;
    q.push_back({~pid, pid});
    if (pid[1:0] == 2'b11) begin
      r = 16'hFFFF;
      if (!zlp) begin
        foreach (p[i]) begin
          q.push_back(p[i]);
          for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ p[i][b];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
          end
        end
      end
      r = ~r;
      q.push_back(r[7:0]);
      q.push_back(r[15:8]);
    end
    return q;
  endfunction

  function automatic int first_diff(input byte_q_t a, input byte_q_t b);
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic byte_q_t seq_123456789();
    byte_q_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    return q;
  endfunction

  // Drives one packet request and records everything the PHY side sees.
  task automatic run_pkt(input logic [3:0] pid, input bit zlp, input int n, input int rmode,
                         input int under_at, input int abort_after);
    int idx;
    int budget;
    bit prev_stall;
    logic [7:0] prev_out;
    obs.delete();
    got_done = 0; got_err = 0; timed_out = 0;
    dr_cnt = 0; stab_bad = 0; lat = -1; wait_cyc = 0;
    valid_at_end = 1'b1; busy_at_end = 1'b1;
    budget = 3 * n + 60;
    idx = 0; prev_stall = 0; prev_out = 8'h00;
    @(posedge clk); #1;
    while (busy_o && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    for (int c = 0; c < budget; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      send_i = (c == 0);
      pid_i  = pid;
      zlp_i  = zlp;
      case (rmode)
        0:       TxReady_i = 1'b1;
        1:       TxReady_i = 1'($urandom_range(0, 1));
        default: TxReady_i = c[0];
      endcase
      data_valid_i = (idx < n && idx != under_at) || (n == 0);
      data_i       = (idx < n) ? pay[idx] : 8'($urandom);
      data_last_i  = (idx == n - 1);
      @(negedge clk);
      if (prev_stall && DataOut_o !== prev_out) stab_bad++;
      prev_stall = TxValid_o && !TxReady_i;
      prev_out   = DataOut_o;
      if (TxValid_o && lat < 0) lat = c;
      if (TxValid_o && TxReady_i) obs.push_back(DataOut_o);
      if (data_ready_o) begin
        dr_cnt++;
        idx++;
      end
      if (done_o || err_o) begin
        got_done = done_o; got_err = err_o;
        valid_at_end = TxValid_o; busy_at_end = busy_o;
        return;
      end
      if (abort_after > 0 && c == abort_after) return;
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; send_i = 1'b1; pid_i = PID_DATA0; data_valid_i = 1'b1; TxReady_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (TxValid_o !== 1'b0) begin n_bad++; $display("FAIL reset_txvalid: got %b want 0", TxValid_o); end
    n_cmp++; if (DataOut_o !== 8'h00) begin n_bad++; $display("FAIL reset_dataout: got %02h want 00", DataOut_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done_o, err_o); end
    n_cmp++; if (data_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", data_ready_o); end
    send_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (TxValid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got valid=%b busy=%b want 0 0", TxValid_o, busy_o); end
  endtask

  task automatic test_ack();
    int d;
    pay.delete();
    exp_q = '{8'hD2};
    run_pkt(PID_ACK, 1'b0, 0, 0, -1, 0);
    d = first_diff(obs, exp_q);
    n_cmp++; if (obs.size() != 1) begin n_bad++; $display("FAIL ack_len: got %0d bytes want 1", obs.size()); end
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL ack_byte[%0d]: got %02h want %02h", d, obs[d], exp_q[d]); end
    n_cmp++; if (got_done !== 1'b1 || got_err !== 1'b0) begin n_bad++; $display("FAIL ack_done: got done=%b err=%b timeout=%b want 1 0 0", got_done, got_err, timed_out); end
    n_cmp++; if (valid_at_end !== 1'b0) begin n_bad++; $display("FAIL ack_txvalid_at_done: got %b want 0", valid_at_end); end
    n_cmp++; if (dr_cnt != 0) begin n_bad++; $display("FAIL ack_data_ready: got %0d pulses want 0", dr_cnt); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL ack_latency: got %0d want 1", lat); end
  endtask

  task automatic test_zlp(input string tag);
    int d;
    pay.delete();
    exp_q = '{8'hC3, 8'h00, 8'h00};
    run_pkt(PID_DATA0, 1'b1, 0, 0, -1, 0);
    d = first_diff(obs, exp_q);
    n_cmp++; if (obs.size() != 3) begin n_bad++; $display("FAIL %s_len: got %0d bytes want 3", tag, obs.size()); end
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL %s_byte[%0d]: got %02h want %02h", tag, d, obs[d], exp_q[d]); end
    n_cmp++; if (got_done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b timeout=%b want 1", tag, got_done, timed_out); end
    n_cmp++; if (dr_cnt != 0) begin n_bad++; $display("FAIL %s_data_ready: got %0d pulses want 0", tag, dr_cnt); end
  endtask

  task automatic test_data_crc(input int rmode, input string tag);
    int d;
    pay = seq_123456789();
    exp_q = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    run_pkt(PID_DATA1, 1'b0, 9, rmode, -1, 0);
    d = first_diff(obs, exp_q);
    n_cmp++; if (obs.size() != 12) begin n_bad++; $display("FAIL %s_len: got %0d bytes want 12", tag, obs.size()); end
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL %s_byte[%0d]: got %02h want %02h", tag, d, obs[d], exp_q[d]); end
    n_cmp++; if (got_done !== 1'b1 || got_err !== 1'b0) begin n_bad++; $display("FAIL %s_done: got done=%b err=%b want 1 0", tag, got_done, got_err); end
    n_cmp++; if (dr_cnt != 9) begin n_bad++; $display("FAIL %s_data_ready: got %0d pulses want 9", tag, dr_cnt); end
    n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL %s_stall_stable: got %0d changes want 0", tag, stab_bad); end
  endtask

  task automatic test_underrun();
    int d;
    pay = seq_123456789();
    exp_q = '{8'h4B, 8'h31, 8'h32};
    run_pkt(PID_DATA1, 1'b0, 9, 0, 2, 0);
    d = first_diff(obs, exp_q);
    n_cmp++; if (obs.size() != 3) begin n_bad++; $display("FAIL underrun_len: got %0d bytes want 3", obs.size()); end
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL underrun_byte[%0d]: got %02h want %02h", d, obs[d], exp_q[d]); end
    n_cmp++; if (got_err !== 1'b1 || got_done !== 1'b0) begin n_bad++; $display("FAIL underrun_err: got err=%b done=%b want 1 0", got_err, got_done); end
    n_cmp++; if (valid_at_end !== 1'b0 || busy_at_end !== 1'b0) begin n_bad++; $display("FAIL underrun_drop: got valid=%b busy=%b want 0 0", valid_at_end, busy_at_end); end
    n_cmp++; if (dr_cnt != 2) begin n_bad++; $display("FAIL underrun_data_ready: got %0d pulses want 2", dr_cnt); end
    test_data_crc(0, "after_underrun");
  endtask

  task automatic test_reset_mid();
    pay = seq_123456789();
    run_pkt(PID_DATA1, 1'b0, 9, 0, -1, 5);
    n_cmp++; if (TxValid_o !== 1'b1) begin n_bad++; $display("FAIL midpkt_active: got valid=%b want 1", TxValid_o); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (TxValid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL midpkt_reset_drop: got valid=%b busy=%b want 0 0", TxValid_o, busy_o); end
    n_cmp++; if (DataOut_o !== 8'h00) begin n_bad++; $display("FAIL midpkt_reset_data: got %02h want 00", DataOut_o); end
    @(negedge clk);
    rst = 1'b1;
    test_zlp("zlp_after_reset");
  endtask

`ifdef USB_TX_PKT_IPG_EN
  task automatic test_ipg();
    bit saw;
    int guard;
    pay.delete();
    run_pkt(PID_ACK, 1'b0, 0, 0, -1, 0);
    repeat (5) @(posedge clk);
    #1 send_i = 1'b1; pid_i = PID_ACK; TxReady_i = 1'b1;
    @(posedge clk);
    #1 send_i = 1'b0;
    saw = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (TxValid_o) saw = 1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL ipg_send_ignored: got valid seen=%b want 0", saw); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL ipg_busy: got %b want 1", busy_o); end
    guard = 0;
    while (busy_o && guard < 60) begin @(negedge clk); guard++; end
    n_cmp++; if (busy_o !== 1'b0 || TxValid_o !== 1'b0) begin n_bad++; $display("FAIL ipg_end: got busy=%b valid=%b want 0 0", busy_o, TxValid_o); end
    test_zlp("zlp_after_gap");
  endtask
`else
  task automatic test_back_to_back();
    pay.delete();
    run_pkt(PID_NAK, 1'b0, 0, 0, -1, 0);
    test_zlp("b2b_zlp");
    n_cmp++; if (wait_cyc != 0) begin n_bad++; $display("FAIL b2b_wait: got %0d idle-wait cycles want 0", wait_cyc); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want 1", lat); end
  endtask
`endif

  task automatic test_max_pkt();
    int d;
    pay.delete();
    for (int i = 0; i < 1024; i++) pay.push_back(8'($urandom));
    // Exactly MAX_PKT bytes: must complete.
    pay.pop_back();
    exp_q = model_pkt(PID_DATA2, 1'b0, pay);
    run_pkt(PID_DATA2, 1'b0, 1023, 0, -1, 0);
    d = first_diff(obs, exp_q);
    n_cmp++; if (obs.size() != 1026) begin n_bad++; $display("FAIL max_len: got %0d bytes want 1026", obs.size()); end
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL max_byte[%0d]: got %02h want %02h", d, obs[d], exp_q[d]); end
    n_cmp++; if (got_done !== 1'b1 || got_err !== 1'b0) begin n_bad++; $display("FAIL max_done: got done=%b err=%b want 1 0", got_done, got_err); end
    // One byte beyond MAX_PKT: aborts after the 1023rd byte.
    pay.push_back(8'h5A);
    run_pkt(PID_DATA2, 1'b0, 1024, 0, -1, 0);
    n_cmp++; if (got_err !== 1'b1 || got_done !== 1'b0) begin n_bad++; $display("FAIL overrun_err: got err=%b done=%b want 1 0", got_err, got_done); end
    n_cmp++; if (obs.size() != 1024 || dr_cnt != 1023) begin n_bad++; $display("FAIL overrun_count: got %0d bytes %0d loads want 1024 1023", obs.size(), dr_cnt); end
    n_cmp++; if (valid_at_end !== 1'b0) begin n_bad++; $display("FAIL overrun_drop: got valid=%b want 0", valid_at_end); end
  endtask

  task automatic test_random();
    logic [3:0] pid;
    bit zlp;
    int n, d;
    repeat (24) begin
      pid = pids[$urandom_range(0, 11)];
      zlp = 1'($urandom_range(0, 3) == 0);
      n   = (pid[1:0] == 2'b11 && !zlp) ? int'($urandom_range(1, 24)) : 0;
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      exp_q = model_pkt(pid, zlp, pay);
      run_pkt(pid, zlp, n, 1, -1, 0);
      d = first_diff(obs, exp_q);
      n_cmp++; if (obs.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_len pid=%h zlp=%b n=%0d: got %0d bytes want %0d", pid, zlp, n, obs.size(), exp_q.size()); end
      n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL rand_byte[%0d] pid=%h n=%0d: got %02h want %02h", d, pid, n, obs[d], exp_q[d]); end
      n_cmp++; if (got_done !== 1'b1 || got_err !== 1'b0) begin n_bad++; $display("FAIL rand_done pid=%h: got done=%b err=%b want 1 0", pid, got_done, got_err); end
      n_cmp++; if (dr_cnt != n) begin n_bad++; $display("FAIL rand_data_ready pid=%h: got %0d want %0d", pid, dr_cnt, n); end
      n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL rand_stall_stable pid=%h: got %0d changes want 0", pid, stab_bad); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ack();
    test_zlp("zlp");
    test_data_crc(0, "data1");
    test_data_crc(2, "ready_toggle");
    test_underrun();
    test_reset_mid();
`ifdef USB_TX_PKT_IPG_EN
    test_ipg();
`else
    test_back_to_back();
`endif
    test_max_pkt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
